// File: rtl/uart_tx_fifo_ctrl.sv
// rtl/uart_tx_fifo_ctrl.sv - byte FIFO and dispatch FSM feeding the UART transmitter
module uart_tx_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  clr_overflow_i,
  input  logic                  tx_done_i,
  output logic                  tx_send_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CW-1:0]         count_o,
  output logic                  busy_o,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    POP       = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Fullness is judged on the current count, so a pop in the same cycle
  // never makes room for a push.
  assign full_o   = (count == CW'(DEPTH));
  assign empty_o  = (count == '0);
  assign count_o  = count;
  assign busy_o   = (state_q != IDLE) || !empty_o;
  assign push     = wr_en_i && !full_o;
  assign drop     = wr_en_i && full_o;
  assign pop      = (state_q == POP);

  // Storage array; deliberately not reset, contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy counter; simultaneous push and pop cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output byte register, only updated by a pop so it holds through SEND/WAIT_DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_o <= '0;
    end else if (pop) begin
      tx_data_o <= mem[rd_ptr];
    end
  end

  // Sticky overflow; a dropped push in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end else if (clr_overflow_i) begin
      overflow_o <= 1'b0;
    end
  end

  // State register with the registered send strobe, high exactly while in SEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_send_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_send_o <= (state_d == SEND);
    end
  end

  // Next-state logic; tx_done_i only matters while waiting for the transmitter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty_o) state_d = POP;
      POP:       state_d = SEND;
      SEND:      state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb/tb_uart_tx_fifo_ctrl.sv - directed self-checking bench for uart_tx_fifo_ctrl
module tb_uart_tx_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = '0;
  logic       clr_overflow_i = 1'b0;
  logic       tx_done_i = 1'b0;
  logic       tx_send_o;
  logic [7:0] tx_data_o;
  logic       full_o;
  logic       empty_o;
  logic [3:0] count_o;
  logic       busy_o;
  logic       overflow_o;

  int passed = 0;
  int total  = 0;

  uart_tx_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en_i        (wr_en_i),
    .wr_data_i      (wr_data_i),
    .clr_overflow_i (clr_overflow_i),
    .tx_done_i      (tx_done_i),
    .tx_send_o      (tx_send_o),
    .tx_data_o      (tx_data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .count_o        (count_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    wr_en_i   = 1'b1;
    wr_data_i = d;
    @(negedge clk);
    wr_en_i   = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done_i = 1'b1;
    @(negedge clk);
    tx_done_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_overflow_i = 1'b1;
    @(negedge clk);
    clr_overflow_i = 1'b0;
  endtask

  task automatic wait_send(input int lim);
    int n = 0;
    while (tx_send_o !== 1'b1 && n < lim) begin
      cyc();
      n++;
    end
    chk("send_seen", {31'd0, tx_send_o}, 32'd1);
  endtask

  initial begin
    int d;

    // Reset values
    repeat (2) cyc();
    chk("rst_count", {28'd0, count_o}, 32'd0);
    chk("rst_empty", {31'd0, empty_o}, 32'd1);
    chk("rst_full", {31'd0, full_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_send", {31'd0, tx_send_o}, 32'd0);
    chk("rst_data", {24'd0, tx_data_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
    rst = 1'b1;
    cyc();

    // Single byte latency
    push(8'h55);
    chk("t1_count_e0", {28'd0, count_o}, 32'd1);
    chk("t1_send_e0", {31'd0, tx_send_o}, 32'd0);
    cyc();
    chk("t1_send_e1", {31'd0, tx_send_o}, 32'd0);
    chk("t1_count_e1", {28'd0, count_o}, 32'd1);
    cyc();
    chk("t1_send_e2", {31'd0, tx_send_o}, 32'd1);
    chk("t1_data_e2", {24'd0, tx_data_o}, 32'h55);
    chk("t1_count_e2", {28'd0, count_o}, 32'd0);
    cyc();
    chk("t1_send_e3", {31'd0, tx_send_o}, 32'd0);
    repeat (3) cyc();
    chk("t1_busy_wait", {31'd0, busy_o}, 32'd1);
    chk("t1_data_hold", {24'd0, tx_data_o}, 32'h55);
    pulse_done();
    chk("t1_busy_done", {31'd0, busy_o}, 32'd0);

    // Three back-to-back bytes, done 20 cycles after each send
    push(8'h41);
    push(8'h42);
    push(8'h43);
    chk("t2_count", {28'd0, count_o}, 32'd2);
    chk("t2_send0", {31'd0, tx_send_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_data", {24'd0, tx_data_o}, 32'h41 + i);
      repeat (19) cyc();
      chk("t2_send_idle", {31'd0, tx_send_o}, 32'd0);
      pulse_done();
      if (i < 2) begin
        chk("t2_send_ed", {31'd0, tx_send_o}, 32'd0);
        cyc();
        chk("t2_send_ed1", {31'd0, tx_send_o}, 32'd0);
        cyc();
        chk("t2_send_ed2", {31'd0, tx_send_o}, 32'd1);
      end
    end
    cyc();
    chk("t2_busy_end", {31'd0, busy_o}, 32'd0);
    chk("t2_empty_end", {31'd0, empty_o}, 32'd1);

    // Fill to DEPTH with the transmitter stalled
    for (int i = 0; i < 9; i++) begin
      wr_en_i   = 1'b1;
      wr_data_i = 8'h60 + 8'(i);
      cyc();
    end
    wr_en_i = 1'b0;
    chk("t3_count_full", {28'd0, count_o}, 32'd8);
    chk("t3_full", {31'd0, full_o}, 32'd1);
    chk("t3_ovf_none", {31'd0, overflow_o}, 32'd0);
    chk("t3_data", {24'd0, tx_data_o}, 32'h60);
    push(8'h99);
    chk("t3_count_drop", {28'd0, count_o}, 32'd8);
    chk("t3_ovf_set", {31'd0, overflow_o}, 32'd1);
    pulse_clr();
    chk("t3_ovf_clr", {31'd0, overflow_o}, 32'd0);
    clr_overflow_i = 1'b1;
    push(8'h98);
    clr_overflow_i = 1'b0;
    chk("t3_set_wins", {31'd0, overflow_o}, 32'd1);
    pulse_clr();
    chk("t3_ovf_clr2", {31'd0, overflow_o}, 32'd0);

    // Push while full, coincident with a pop
    pulse_done();
    cyc();
    push(8'hAA);
    chk("t4_count", {28'd0, count_o}, 32'd7);
    chk("t4_ovf", {31'd0, overflow_o}, 32'd1);
    chk("t4_send", {31'd0, tx_send_o}, 32'd1);
    chk("t4_data", {24'd0, tx_data_o}, 32'h61);
    cyc();

    // Asynchronous reset while waiting for done
    #2 rst = 1'b0;
    #1;
    chk("t6_count", {28'd0, count_o}, 32'd0);
    chk("t6_empty", {31'd0, empty_o}, 32'd1);
    chk("t6_send", {31'd0, tx_send_o}, 32'd0);
    chk("t6_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_ovf", {31'd0, overflow_o}, 32'd0);
    chk("t6_data", {24'd0, tx_data_o}, 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    push(8'h5A);
    chk("t6_send_e0", {31'd0, tx_send_o}, 32'd0);
    cyc();
    chk("t6_send_e1", {31'd0, tx_send_o}, 32'd0);
    cyc();
    chk("t6_send_e2", {31'd0, tx_send_o}, 32'd1);
    chk("t6_data_e2", {24'd0, tx_data_o}, 32'h5A);
    repeat (4) cyc();
    pulse_done();

    // Stream 20 bytes with random done delays
    push(8'h00);
    push(8'h01);
    for (int k = 0; k < 20; k++) begin
      wait_send(100);
      chk("t5_data", {24'd0, tx_data_o}, 32'(k));
      d = $urandom_range(40, 5);
      for (int j = 0; j < d; j++) begin
        if (j == 0 && k + 2 < 20) begin
          push(8'(k + 2));
        end else begin
          cyc();
        end
      end
      pulse_done();
    end
    repeat (3) cyc();
    chk("t5_ovf", {31'd0, overflow_o}, 32'd0);
    chk("t5_empty", {31'd0, empty_o}, 32'd1);
    chk("t5_busy", {31'd0, busy_o}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
